mos_mux4_switch_model: RTL and testbench

Clocked, synthesizable behavioural model of the team's transistor-level 4:1 multiplexer pair.
- Path N: inverter + 3-input NAND + 4-input NAND structure.
- Path T: inverting tri-state buffer tree.

Both paths are evaluated in parallel. Their outputs are registered after a programmable settle interval that stands in for switch propagation delay, and the two results are cross-checked. The block sits in the standard-cell verification harness as the golden reference for the switch-level mux netlists.

---
 rtl/mos_mux_pkg.sv | 40 ++++
 rtl/mos_tsb_inv.sv | 21 ++
 rtl/mos_mux4_switch_model.sv | 141 ++++++++++++++
 tb/tb_mos_mux4_switch_model.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mos_mux_pkg.sv
// mos_mux_pkg
// Shared definitions for the switch-level 4:1 mux reference model:
//   - select encodings (sel[1]=s1, sel[0]=s0)
//   - default settle interval and stability counter width
//   - NAND primitives used by the NAND-structure path
//   - two-driver node resolution used by the tri-state path
package mos_mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int SETTLE_CYCLES_DEF = 2;

    // Settle interval is limited to 1..15, so four bits always suffice.
    localparam int CNT_W = 4;

    function automatic logic nand3(input logic x, input logic y, input logic z);
        return ~(x & y & z);
    endfunction

    function automatic logic nand4(input logic w, input logic x, input logic y, input logic z);
        return ~(w & x & y & z);
    endfunction

    // Value of a node shared by two tri-state drivers. A disabled driver
    // contributes nothing; the caller separately checks that exactly one
    // driver is enabled, so the OR never hides a real contention.
    function automatic logic node_resolve(input logic y0, input logic drv0,
                                          input logic y1, input logic drv1);
        return (y0 & drv0) | (y1 & drv1);
    endfunction

    // Exactly one driver on the node: neither floating nor contending.
    function automatic logic node_ok(input logic drv0, input logic drv1);
        return drv0 ^ drv1;
    endfunction

endpackage

// File: rtl/mos_tsb_inv.sv
// mos_tsb_inv
// Single-lane inverting tri-state buffer stage.
// When enabled it drives the inverse of din; when disabled it releases the
// node. Instead of a real high-Z the release is modelled as dout=0 with
// drive=0, so the owning node can be resolved and checked in plain logic.
// Ports:
//   din    input   data into the stage
//   en     input   output enable
//   dout   output  ~din while enabled, 0 while released
//   drive  output  high when the stage is actively driving its node
module mos_tsb_inv (
    input  logic din,
    input  logic en,
    output logic dout,
    output logic drive
);

    assign dout  = en & ~din;
    assign drive = en;

endmodule

// File: rtl/mos_mux4_switch_model.sv
// mos_mux4_switch_model
// Clocked golden reference for the transistor-level 4:1 mux pair.
// Path N follows the inverter + 3-input NAND + 4-input NAND netlist.
// Path T follows the inverting tri-state tree:
//   ab = ~(s0 ? b : a), cd = ~(s0 ? d : c), w = ~(s1 ? cd : ab).
// Both paths are evaluated from a registered input snapshot. Results are
// loaded only after the snapshot has stayed unchanged for SETTLE_CYCLES
// edges, which stands in for switch propagation delay.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   sel       select, sel[0]=s0, sel[1]=s1
//   in_a..d   lane data for sel 00/01/10/11
//   out_nand  registered path N result
//   out_tsb   registered path T result
//   settled   outputs reflect the current, stable inputs
//   mismatch  sticky: paths disagreed, or a tri-state node was floating or
//             contending, at some update
module mos_mux4_switch_model
    import mos_mux_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] out_nand,
    output logic [WIDTH-1:0] out_tsb,
    output logic             settled,
    output logic             mismatch
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("mos_mux4_switch_model: SETTLE_CYCLES must be in 1..15");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("mos_mux4_switch_model: WIDTH must be at least 1");
    end

    localparam int SNAP_W = 2 + 4 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [SNAP_W-1:0] snap_d;
    logic [SNAP_W-1:0] snap_q;
    logic              changed;
    logic [CNT_W-1:0]  cnt_q;

    assign snap_d  = {sel, in_a, in_b, in_c, in_d};
    assign changed = (snap_d != snap_q);

    // The switch paths see only the snapshot, so both evaluate the exact
    // inputs that were held stable through the settle interval.
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sc;
    logic [WIDTH-1:0] sd;

    assign {s1, s0, sa, sb, sc, sd} = snap_q;

    logic [WIDTH-1:0] path_n;
    logic [WIDTH-1:0] path_t;
    logic [WIDTH-1:0] tsb_fault;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        // Path N
        logic ns0;
        logic ns1;
        logic o1;
        logic o2;
        logic o3;
        logic o4;

        assign ns0 = ~s0;
        assign ns1 = ~s1;
        assign o1  = nand3(sa[i], ns1, ns0);
        assign o2  = nand3(sb[i], ns1, s0);
        assign o3  = nand3(sc[i], s1,  ns0);
        assign o4  = nand3(sd[i], s1,  s0);
        assign path_n[i] = nand4(o1, o2, o3, o4);

        // Path T: six inverting tri-state stages per lane
        logic y_a, drv_a, y_b, drv_b;
        logic y_c, drv_c, y_d, drv_d;
        logic y_ab, drv_ab, y_cd, drv_cd;
        logic ab;
        logic cd;

        mos_tsb_inv u_tsb_a (.din(sa[i]), .en(~s0), .dout(y_a), .drive(drv_a));
        mos_tsb_inv u_tsb_b (.din(sb[i]), .en(s0),  .dout(y_b), .drive(drv_b));
        mos_tsb_inv u_tsb_c (.din(sc[i]), .en(~s0), .dout(y_c), .drive(drv_c));
        mos_tsb_inv u_tsb_d (.din(sd[i]), .en(s0),  .dout(y_d), .drive(drv_d));

        assign ab = node_resolve(y_a, drv_a, y_b, drv_b);
        assign cd = node_resolve(y_c, drv_c, y_d, drv_d);

        mos_tsb_inv u_tsb_ab (.din(ab), .en(~s1), .dout(y_ab), .drive(drv_ab));
        mos_tsb_inv u_tsb_cd (.din(cd), .en(s1),  .dout(y_cd), .drive(drv_cd));

        assign path_t[i] = node_resolve(y_ab, drv_ab, y_cd, drv_cd);

        assign tsb_fault[i] = ~(node_ok(drv_a, drv_b) &
                                node_ok(drv_c, drv_d) &
                                node_ok(drv_ab, drv_cd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= '0;
            cnt_q    <= '0;
            out_nand <= '0;
            out_tsb  <= '0;
            settled  <= 1'b0;
            mismatch <= 1'b0;
        end else if (changed) begin
            snap_q  <= snap_d;
            cnt_q   <= '0;
            settled <= 1'b0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
            // Update happens only on the edge that brings the counter to
            // its saturation value; afterwards the outputs just hold.
            if (cnt_q == CNT_LAST) begin
                out_nand <= path_n;
                out_tsb  <= path_t;
                settled  <= 1'b1;
                if ((path_n != path_t) || (|tsb_fault)) begin
                    mismatch <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mos_mux4_switch_model.sv
module tb_mos_mux4_switch_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;

    logic       a1, b1, c1, d1;
    logic       on1, ot1, st1, mm1;

    logic [3:0] a4, b4, c4, d4;
    logic [3:0] on4, ot4;
    logic       st4, mm4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mos_mux4_switch_model #(.WIDTH(1), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_a(a1), .in_b(b1), .in_c(c1), .in_d(d1),
        .out_nand(on1), .out_tsb(ot1), .settled(st1), .mismatch(mm1)
    );

    mos_mux4_switch_model #(.WIDTH(4), .SETTLE_CYCLES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_a(a4), .in_b(b4), .in_c(c4), .in_d(d4),
        .out_nand(on4), .out_tsb(ot4), .settled(st4), .mismatch(mm4)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sweep with a=0,b=1,c=1,d=0: expected outputs written out by hand.
    logic [1:0] sw_from [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [1:0] sw_to   [8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01};
    logic       ex_from [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    logic       ex_to   [8] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    initial begin
        logic [5:0] vv;
        logic       ex;

        rst_n = 1'b0;
        sel   = 2'b00;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b1; d1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; d4 = 4'h0;

        // Reset
        edges(2);
        chk("rst_nand", on1, 1'b0);
        chk("rst_tsb", ot1, 1'b0);
        chk("rst_settled", st1, 1'b0);
        chk("rst_mismatch", mm1, 1'b0);
        chk("rst_w4_nand", on4, 4'h0);
        rst_n = 1'b1;
        edges(2);
        chk("rel_settled_early", st1, 1'b0);
        edges(1);
        chk("rel_settled", st1, 1'b1);
        chk("rel_nand", on1, 1'b0);
        chk("rel_tsb", ot1, 1'b0);

        // Select sweep
        for (int i = 0; i < 8; i++) begin
            sel = sw_from[i];
            edges(5);
            chk($sformatf("sweep%0d_from_nand", i), on1, ex_from[i]);
            chk($sformatf("sweep%0d_from_tsb", i), ot1, ex_from[i]);
            sel = sw_to[i];
            edges(2);
            chk($sformatf("sweep%0d_hold_nand", i), on1, ex_from[i]);
            chk($sformatf("sweep%0d_hold_settled", i), st1, 1'b0);
            edges(3);
            chk($sformatf("sweep%0d_to_nand", i), on1, ex_to[i]);
            chk($sformatf("sweep%0d_to_tsb", i), ot1, ex_to[i]);
            chk($sformatf("sweep%0d_to_settled", i), st1, 1'b1);
            chk($sformatf("sweep%0d_mismatch", i), mm1, 1'b0);
        end

        // Settle gating: sel=01 now, outputs 1. Toggle between 00 and 11
        // (both select a 0) so a premature update would be visible.
        for (int i = 0; i < 6; i++) begin
            sel = (i % 2 == 0) ? 2'b00 : 2'b11;
            edges(1);
            chk($sformatf("gate%0d_settled", i), st1, 1'b0);
            chk($sformatf("gate%0d_nand", i), on1, 1'b1);
            chk($sformatf("gate%0d_tsb", i), ot1, 1'b1);
        end
        edges(1);
        chk("gate_hold_settled", st1, 1'b0);
        chk("gate_hold_nand", on1, 1'b1);
        edges(1);
        chk("gate_done_settled", st1, 1'b1);
        chk("gate_done_nand", on1, 1'b0);
        chk("gate_done_tsb", ot1, 1'b0);

        // Exhaustive WIDTH=1
        for (int v = 0; v < 64; v++) begin
            vv  = v[5:0];
            sel = vv[5:4];
            a1  = vv[3]; b1 = vv[2]; c1 = vv[1]; d1 = vv[0];
            case (vv[5:4])
                2'b00:   ex = vv[3];
                2'b01:   ex = vv[2];
                2'b10:   ex = vv[1];
                default: ex = vv[0];
            endcase
            edges(3);
            chk($sformatf("exh%0d_nand", v), on1, ex);
            chk($sformatf("exh%0d_tsb", v), ot1, ex);
        end
        chk("exh_mismatch", mm1, 1'b0);
        chk("exh_settled", st1, 1'b1);

        // Mid-interval reset: state is sel=11, all inputs 1, outputs 1.
        sel = 2'b00;
        edges(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_nand", on1, 1'b0);
        chk("midrst_tsb", ot1, 1'b0);
        chk("midrst_settled", st1, 1'b0);
        chk("midrst_mismatch", mm1, 1'b0);
        edges(2);
        rst_n = 1'b1;
        edges(2);
        chk("midrst_rel_settled_early", st1, 1'b0);
        chk("midrst_rel_nand_early", on1, 1'b0);
        edges(1);
        chk("midrst_rel_settled", st1, 1'b1);
        chk("midrst_rel_nand", on1, 1'b1);
        chk("midrst_rel_tsb", ot1, 1'b1);

        // WIDTH=4
        sel = 2'b10;
        a4 = 4'h5; b4 = 4'h5; c4 = 4'hA; d4 = 4'h5;
        edges(3);
        chk("w4_nand", on4, 4'hA);
        chk("w4_tsb", ot4, 4'hA);
        chk("w4_settled", st4, 1'b1);
        chk("w4_mismatch", mm4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
